// File: rtl/text_scanout.sv
// Text-mode scanout: follows the active raster, fetches character/attribute
// cells and font rows, and emits palette RGB with sync/DE delayed by three clocks.
module text_scanout #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_de,
    input  logic              in_hs,
    input  logic              in_vs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_text,
    input  logic [7:0]        rd_attr,
    output logic [11:0]       font_addr,
    input  logic [7:0]        font_data,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic              cursor_en,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic [23:0]       out_rgb
);

    localparam logic [9:0]        COLS_X = 10'(COLS);
    localparam logic [8:0]        ROWS_Y = 9'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [9:0]        X_MAX  = 10'd1023;

    // 16-entry CGA-style palette; index 6 is brown rather than dark yellow.
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [7:0] lift;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        lift = idx[3] ? 8'h55 : 8'h00;
        r = (idx[2] ? 8'hAA : 8'h00) + lift;
        g = (idx == 4'd6) ? 8'h55 : ((idx[1] ? 8'hAA : 8'h00) + lift);
        b = (idx[0] ? 8'hAA : 8'h00) + lift;
        return {r, g, b};
    endfunction

    logic [9:0]        x_cnt_r;
    logic [8:0]        y_cnt_r;
    logic              de_d_r;
    logic              vs_d_r;
    logic [5:0]        frame_r;
    logic              synced_r;
    logic              run_r;

    logic              de1_r, hs1_r, vs1_r, area1_r, match1_r;
    logic              blink1_r, curph1_r, sync1_r;
    logic [2:0]        bit1_r;
    logic [3:0]        grow1_r;

    logic              de2_r, hs2_r, vs2_r, area2_r, match2_r;
    logic              blink2_r, curph2_r, sync2_r, crow2_r;
    logic [2:0]        bit2_r;
    logic [7:0]        attr2_r;

    logic [6:0]        char_col_s;
    logic [4:0]        char_row_s;
    logic              area_s;
    logic [ADDR_W-1:0] cell_s;
    logic              vs_rise_s;
    logic              de_fall_s;
    logic              match_s;
    logic              glyph_bit_s;
    logic              cursor_on_s;
    logic              fg_on_s;
    logic [3:0]        idx_s;
    logic [23:0]       pix_s;

    assign char_col_s = x_cnt_r[9:3];
    assign char_row_s = y_cnt_r[8:4];
    assign area_s     = ({3'b000, char_col_s} < COLS_X) && ({4'b0000, char_row_s} < ROWS_Y);
    assign cell_s     = ADDR_W'(char_row_s) * COLS_A + ADDR_W'(char_col_s);
    assign vs_rise_s  = in_vs & ~vs_d_r;
    assign de_fall_s  = de_d_r & ~in_de;
    assign match_s    = cursor_en & (rd_addr == cursor_addr);

    // S0 text buffer address; parked at cell 0 outside the text area.
    always_comb begin
        rd_addr = {ADDR_W{1'b0}};
        if (area_s) begin
            rd_addr = cell_s;
        end else begin
            rd_addr = {ADDR_W{1'b0}};
        end
    end

    // S1 font address from the freshly read character; zero until the pipe runs.
    always_comb begin
        font_addr = 12'd0;
        if (run_r) begin
            font_addr = {rd_text, grow1_r};
        end else begin
            font_addr = 12'd0;
        end
    end

    // Raster counters, frame counter and sync-acquired flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt_r  <= 10'd0;
            y_cnt_r  <= 9'd0;
            de_d_r   <= 1'b0;
            vs_d_r   <= 1'b0;
            frame_r  <= 6'd0;
            synced_r <= 1'b0;
            run_r    <= 1'b0;
        end else begin
            de_d_r <= in_de;
            vs_d_r <= in_vs;
            run_r  <= 1'b1;
            if (!in_de) begin
                x_cnt_r <= 10'd0;
            end else if (x_cnt_r != X_MAX) begin
                x_cnt_r <= x_cnt_r + 10'd1;
            end else begin
                x_cnt_r <= x_cnt_r;
            end
            // A vsync edge that lands on a DE fall restarts the frame at line 0.
            if (vs_rise_s) begin
                y_cnt_r  <= 9'd0;
                frame_r  <= frame_r + 6'd1;
                synced_r <= 1'b1;
            end else if (de_fall_s) begin
                y_cnt_r <= y_cnt_r + 9'd1;
            end else begin
                y_cnt_r <= y_cnt_r;
            end
        end
    end

    // S1 register: per-pixel context captured alongside the buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            de1_r    <= 1'b0;
            hs1_r    <= 1'b0;
            vs1_r    <= 1'b0;
            area1_r  <= 1'b0;
            match1_r <= 1'b0;
            blink1_r <= 1'b0;
            curph1_r <= 1'b0;
            sync1_r  <= 1'b0;
            bit1_r   <= 3'd0;
            grow1_r  <= 4'd0;
        end else begin
            de1_r    <= in_de;
            hs1_r    <= in_hs;
            vs1_r    <= in_vs;
            area1_r  <= area_s;
            match1_r <= match_s;
            blink1_r <= frame_r[5];
            curph1_r <= frame_r[4];
            sync1_r  <= synced_r;
            bit1_r   <= x_cnt_r[2:0];
            grow1_r  <= y_cnt_r[3:0];
        end
    end

    // S2 register: attribute arrives here, font row is fetched during this stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            de2_r    <= 1'b0;
            hs2_r    <= 1'b0;
            vs2_r    <= 1'b0;
            area2_r  <= 1'b0;
            match2_r <= 1'b0;
            blink2_r <= 1'b0;
            curph2_r <= 1'b0;
            sync2_r  <= 1'b0;
            crow2_r  <= 1'b0;
            bit2_r   <= 3'd0;
            attr2_r  <= 8'd0;
        end else begin
            de2_r    <= de1_r;
            hs2_r    <= hs1_r;
            vs2_r    <= vs1_r;
            area2_r  <= area1_r;
            match2_r <= match1_r;
            blink2_r <= blink1_r;
            curph2_r <= curph1_r;
            sync2_r  <= sync1_r;
            crow2_r  <= (grow1_r[3:1] == 3'b111);
            bit2_r   <= bit1_r;
            attr2_r  <= rd_attr;
        end
    end

    assign glyph_bit_s = font_data[3'd7 - bit2_r];
    assign cursor_on_s = match2_r & ~curph2_r & crow2_r;
    assign fg_on_s     = cursor_on_s | (glyph_bit_s & ~(attr2_r[7] & blink2_r));

    // Colour selection; anything blanked, off-screen or unsynced is black.
    always_comb begin
        idx_s = 4'd0;
        pix_s = 24'h000000;
        if (fg_on_s) begin
            idx_s = attr2_r[3:0];
        end else begin
            idx_s = {1'b0, attr2_r[6:4]};
        end
        if (de2_r && area2_r && sync2_r) begin
            pix_s = palette(idx_s);
        end else begin
            pix_s = 24'h000000;
        end
    end

    // S3 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_rgb <= 24'h000000;
        end else begin
            out_de  <= de2_r;
            out_hs  <= hs2_r;
            out_vs  <= vs2_r;
            out_rgb <= pix_s;
        end
    end

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: random buffer/font contents, a pixel-level reference
// model computed from cell geometry and a palette table, and directed scenarios.
module tb_text_scanout;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;
    localparam logic [23:0] PAL [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_de, in_hs, in_vs, cursor_en;
    logic [ADDR_W-1:0] rd_addr, cursor_addr;
    logic [7:0]        rd_text, rd_attr, font_data;
    logic [11:0]       font_addr;
    logic              out_de, out_hs, out_vs;
    logic [23:0]       out_rgb;

    text_scanout #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .rd_addr(rd_addr), .rd_text(rd_text), .rd_attr(rd_attr),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_addr(cursor_addr), .cursor_en(cursor_en),
        .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb));

    logic [7:0] text_mem [2048];
    logic [7:0] attr_mem [2048];
    logic [7:0] font_mem [4096];

    always @(posedge clk) begin
        rd_text   <= text_mem[rd_addr];
        rd_attr   <= attr_mem[rd_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct packed {logic de; logic hs; logic vs; logic [23:0] rgb;} exp_t;
    exp_t        q[$];
    exp_t        cur;
    logic [10:0] exp_rd_addr;
    logic [11:0] exp_font;
    int mx, my, mf;
    bit msync, m_pde, m_pvs;
    int checks = 0;
    int failures = 0;

    function automatic int cell_addr(int x, int y);
        if ((x / 8) < COLS && (y / 16) < ROWS) return (y / 16) * COLS + (x / 8);
        return 0;
    endfunction

    function automatic logic [23:0] pixel(int x, int y);
        int a;
        logic [7:0] at, g;
        bit blink, curs, fg;
        if ((x / 8) >= COLS || (y / 16) >= ROWS) return 24'h0;
        a     = cell_addr(x, y);
        at    = attr_mem[a];
        g     = font_mem[int'(text_mem[a]) * 16 + (y % 16)];
        blink = at[7] && (mf >= 32);
        curs  = cursor_en && (a == int'(cursor_addr)) && ((mf % 32) < 16) && ((y % 16) >= 14);
        fg    = curs || (g[7 - (x % 8)] && !blink);
        return fg ? PAL[at % 16] : PAL[(at / 16) % 8];
    endfunction

    // One clock: drive inputs, predict the sample's output three clocks on, advance the model.
    task automatic tick(input logic de, input logic hs, input logic vs, input logic rst);
        exp_t e;
        logic [3:0] gr;
        @(negedge clk);
        reset = rst; in_de = de; in_hs = hs; in_vs = vs;
        if (rst) begin
            q.delete();
            q.push_back(27'd0);
            q.push_back(27'd0);
            mx = 0; my = 0; mf = 0; msync = 0; m_pde = 0; m_pvs = 0;
            exp_font = 12'd0;
            cur = 27'd0;
        end else begin
            e.de = de; e.hs = hs; e.vs = vs;
            e.rgb = (de && msync) ? pixel(mx, my) : 24'h0;
            q.push_back(e);
            gr = 4'(my % 16);
            exp_font = {text_mem[cell_addr(mx, my)], gr};
            if (vs && !m_pvs) begin
                my = 0; mf = (mf + 1) % 64; msync = 1;
            end else if (m_pde && !de) begin
                my = my + 1;
            end
            mx = de ? ((mx < 1023) ? mx + 1 : 1023) : 0;
            m_pde = de; m_pvs = vs;
            cur = q.pop_front();
        end
        exp_rd_addr = 11'(cell_addr(mx, my));
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) begin
            text_mem[i] = 8'($urandom);
            attr_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr} !== 50'd0) begin
                failures++;
                $display("FAIL reset_state: got %h want 0", {out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr});
            end
        end
        for (int p = 0; p < 20; p++) begin
            tick(p < 16, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({out_de, out_hs, out_vs, out_rgb} !== cur || out_rgb !== 24'h0) begin
                failures++;
                $display("FAIL unsynced_black: got %h want %h", {out_de, out_hs, out_vs, out_rgb}, cur);
            end
        end
    endtask

    task automatic test_first_char();
        logic [23:0] want;
        cursor_en = 1'b0;
        text_mem[0] = 8'h41; attr_mem[0] = 8'h1F; font_mem[12'h410] = 8'h18;
        vsync_pulse();
        for (int p = 0; p < 22; p++) begin
            tick(p < 16, (p >= 18 && p < 20), 1'b0, 1'b0);
            checks++;
            if ({out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr} !== {cur, exp_rd_addr, exp_font}) begin
                failures++;
                $display("FAIL first_char_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr}, {cur, exp_rd_addr, exp_font});
            end
            if (p == 1) begin
                checks++;
                if (out_de !== 1'b0) begin
                    failures++;
                    $display("FAIL first_char_latency: out_de got %b want 0", out_de);
                end
            end
            if (p >= 2 && p < 10) begin
                want = (p == 5 || p == 6) ? 24'hFFFFFF : 24'h0000AA;
                checks++;
                if ({out_de, out_rgb} !== {1'b1, want}) begin
                    failures++;
                    $display("FAIL first_char_pixel%0d: got %b/%h want 1/%h", p - 2, out_de, out_rgb, want);
                end
            end
        end
    endtask

    task automatic test_addr();
        vsync_pulse();
        for (int ln = 0; ln < 17; ln++) begin
            for (int p = 0; p < 28; p++) begin
                tick(p < 24, p == 25, 1'b0, 1'b0);
                checks++;
                if ({out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr} !== {cur, exp_rd_addr, exp_font}) begin
                    failures++;
                    $display("FAIL addr_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr}, {cur, exp_rd_addr, exp_font});
                end
                if (ln == 16 && p == 7) begin
                    checks++;
                    if (rd_addr !== 11'd81) begin
                        failures++;
                        $display("FAIL rd_addr_x8_y16: got %0d want 81", rd_addr);
                    end
                end
                if (ln == 16 && p == 8) begin
                    checks++;
                    if (font_addr !== {text_mem[81], 4'd0}) begin
                        failures++;
                        $display("FAIL font_addr_x8_y16: got %h want %h", font_addr, {text_mem[81], 4'd0});
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int nl, w, b;
        for (int fr = 0; fr < 3; fr++) begin
            init_mem();
            cursor_addr = 11'($urandom_range(0, 3 * COLS - 1));
            cursor_en   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) vsync_pulse();
            vsync_pulse();
            nl = $urandom_range(20, 40);
            for (int ln = 0; ln < nl; ln++) begin
                w = $urandom_range(8, 120);
                b = $urandom_range(3, 8);
                for (int p = 0; p < w + b; p++) begin
                    tick(p < w, p == w + 1, 1'b0, 1'b0);
                    checks++;
                    if ({out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr} !== {cur, exp_rd_addr, exp_font}) begin
                        failures++;
                        $display("FAIL random_frame: got %h want %h", {out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr}, {cur, exp_rd_addr, exp_font});
                    end
                end
            end
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_blink();
        int tgts [5] = '{1, 31, 32, 63, 0};
        logic [23:0] want;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        cursor_en = 1'b0;
        text_mem[0] = 8'h01; attr_mem[0] = 8'h8E;
        for (int r = 0; r < 16; r++) font_mem[16 + r] = 8'hFF;
        foreach (tgts[k]) begin
            do vsync_pulse(); while (mf != tgts[k]);
            for (int p = 0; p < 12; p++) begin
                tick(p < 8, 1'b0, 1'b0, 1'b0);
                checks++;
                if ({out_de, out_hs, out_vs, out_rgb} !== cur) begin
                    failures++;
                    $display("FAIL blink_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb}, cur);
                end
                if (p == 2) begin
                    want = (tgts[k] < 32) ? 24'hFFFF55 : 24'h000000;
                    checks++;
                    if (out_rgb !== want) begin
                        failures++;
                        $display("FAIL blink_frame%0d: got %h want %h", tgts[k], out_rgb, want);
                    end
                end
            end
        end
    endtask

    task automatic test_cursor();
        int tgts [3] = '{1, 20, 40};
        logic [23:0] want;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        cursor_addr = 11'd5; cursor_en = 1'b1;
        text_mem[5] = 8'h02;
        for (int r = 0; r < 16; r++) font_mem[32 + r] = 8'h00;
        foreach (tgts[k]) begin
            attr_mem[5] = (tgts[k] == 40) ? 8'h87 : 8'h07;
            do vsync_pulse(); while (mf != tgts[k]);
            for (int ln = 0; ln < 16; ln++) begin
                for (int p = 0; p < 52; p++) begin
                    tick(p < 48, p == 49, 1'b0, 1'b0);
                    checks++;
                    if ({out_de, out_hs, out_vs, out_rgb} !== cur) begin
                        failures++;
                        $display("FAIL cursor_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb}, cur);
                    end
                    if (p == 42) begin
                        want = (ln >= 14 && (tgts[k] % 32) < 16) ? 24'hAAAAAA : 24'h000000;
                        checks++;
                        if (out_rgb !== want) begin
                            failures++;
                            $display("FAIL cursor_f%0d_row%0d: got %h want %h", tgts[k], ln, out_rgb, want);
                        end
                    end
                end
            end
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_outside();
        init_mem();
        vsync_pulse();
        for (int ln = 0; ln < 402; ln++) begin
            for (int p = 0; p < 10; p++) begin
                tick(p < 8, 1'b0, 1'b0, 1'b0);
                checks++;
                if ({out_de, out_hs, out_vs, out_rgb, rd_addr} !== {cur, exp_rd_addr}) begin
                    failures++;
                    $display("FAIL outside_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb, rd_addr}, {cur, exp_rd_addr});
                end
                if (ln >= 400 && p >= 2) begin
                    checks++;
                    if ({out_de, out_rgb} !== {1'b1, 24'h0}) begin
                        failures++;
                        $display("FAIL outside_y400: got %b/%h want 1/000000", out_de, out_rgb);
                    end
                end
            end
        end
        vsync_pulse();
        for (int p = 0; p < 1044; p++) begin
            tick(p < 1040, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({out_de, out_hs, out_vs, out_rgb} !== cur) begin
                failures++;
                $display("FAIL wide_line_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb}, cur);
            end
            if (p >= 640 && p < 1040) begin
                checks++;
                if (rd_addr !== 11'd0) begin
                    failures++;
                    $display("FAIL wide_line_addr: got %0d want 0", rd_addr);
                end
            end
        end
    endtask

    task automatic test_vs_coincide();
        init_mem();
        vsync_pulse();
        for (int ln = 0; ln < 5; ln++) begin
            for (int p = 0; p < 20; p++) begin
                if (ln == 3 && p >= 10 && p < 12) tick(1'b0, 1'b0, 1'b1, 1'b0);
                else tick((ln == 3) ? p < 10 : p < 16, 1'b0, 1'b0, 1'b0);
                checks++;
                if ({out_de, out_hs, out_vs, out_rgb, font_addr} !== {cur, exp_font}) begin
                    failures++;
                    $display("FAIL vs_coincide_model: got %h want %h", {out_de, out_hs, out_vs, out_rgb, font_addr}, {cur, exp_font});
                end
                if (ln == 4 && p == 0) begin
                    checks++;
                    if (font_addr[3:0] !== 4'd0) begin
                        failures++;
                        $display("FAIL vs_coincide_row: glyph row got %0d want 0", font_addr[3:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        vsync_pulse();
        for (int p = 0; p < 10; p++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr} !== 50'd0) begin
            failures++;
            $display("FAIL reset_mid_flush: got %h want 0", {out_de, out_hs, out_vs, out_rgb, rd_addr, font_addr});
        end
        for (int ln = 0; ln < 3; ln++) begin
            if (ln == 2) vsync_pulse();
            for (int p = 0; p < 24; p++) begin
                tick(p < 20, p == 21, 1'b0, 1'b0);
                checks++;
                if ({out_de, out_hs, out_vs, out_rgb} !== cur || (ln < 2 && out_rgb !== 24'h0)) begin
                    failures++;
                    $display("FAIL reset_mid_line%0d: got %h want %h", ln, {out_de, out_hs, out_vs, out_rgb}, cur);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
        cursor_en = 1'b0; cursor_addr = 11'd0;
        init_mem();
        test_reset();
        test_first_char();
        test_addr();
        test_random();
        test_blink();
        test_cursor();
        test_outside();
        test_vs_coincide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
